// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, RV32I major opcodes and the decoded
// operand-stage entry carried through the skid buffer.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 7;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b1000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SRA  = 4'b1101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111
  } alu_op_t;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    alu_op_t           alu_op;
    logic [XLEN-1:0]   operand1;
    logic [XLEN-1:0]   operand2;
    logic [REG_AW-1:0] rd;
    logic              illegal;
  } dec_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I integer-ALU decoder: turns an instruction plus register
// read data into an ALU opcode, two operands and a destination register.
module alu_decode
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output dec_entry_t      entry_c
);

  logic [OPC_W-1:0]  opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_u;
  logic [XLEN-1:0]   shamt;
  logic              legal;

  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign funct7  = instr[31:25];
  // x0 always reads as zero regardless of what the register file returns
  assign rs1_val = (rs1 == '0) ? '0 : rs1_data;
  assign rs2_val = (rs2 == '0) ? '0 : rs2_data;
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt   = XLEN'(rs2);

  always_comb begin
    entry_c          = '0;
    entry_c.alu_op   = ALU_ADD;
    legal            = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal            = (funct7 == 7'h00) ||
                           ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        entry_c.alu_op   = alu_op_t'({instr[30], funct3});
        entry_c.operand1 = rs1_val;
        entry_c.operand2 = rs2_val;
      end
      OPC_OP_IMM: begin
        entry_c.operand1 = rs1_val;
        case (funct3)
          3'b001: begin
            legal            = (funct7 == 7'h00);
            entry_c.alu_op   = ALU_SLL;
            entry_c.operand2 = shamt;
          end
          3'b101: begin
            legal            = (funct7 == 7'h00) || (funct7 == 7'h20);
            entry_c.alu_op   = alu_op_t'({instr[30], 3'b101});
            entry_c.operand2 = shamt;
          end
          default: begin
            legal            = 1'b1;
            entry_c.alu_op   = alu_op_t'({1'b0, funct3});
            entry_c.operand2 = imm_i;
          end
        endcase
      end
      OPC_LUI: begin
        legal            = 1'b1;
        entry_c.operand2 = imm_u;
      end
      OPC_AUIPC: begin
        legal            = 1'b1;
        entry_c.operand1 = pc;
        entry_c.operand2 = imm_u;
      end
      default: legal = 1'b0;
    endcase

    // Unsupported encodings still travel down the pipe, but carry no payload
    if (legal) begin
      entry_c.rd = rd;
    end else begin
      entry_c         = '0;
      entry_c.alu_op  = ALU_ADD;
      entry_c.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: decodes an RV32I instruction and buffers the decoded
// result in a 2-entry skid buffer between decode and execute.
module alu_operand_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_op,
  output logic [XLEN-1:0]   out_operand1,
  output logic [XLEN-1:0]   out_operand2,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_illegal
);

  dec_entry_t  dec_c;
  dec_entry_t  head;
  dec_entry_t  tail;
  skid_state_t state;
  logic        accept_c;
  logic        drain_c;

  alu_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .entry_c  (dec_c)
  );

  assign accept_c = in_valid && in_ready;
  assign drain_c  = out_valid && out_ready;

  // Head entry drives the outputs directly; tail only fills while head is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      head      <= '0;
      tail      <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept_c) begin
            head      <= dec_c;
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept_c && drain_c) begin
            head <= dec_c;
          end else if (accept_c) begin
            tail     <= dec_c;
            state    <= ST_TWO;
            in_ready <= 1'b0;
          end else if (drain_c) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (drain_c) begin
            head     <= tail;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_alu_op   = head.alu_op;
  assign out_operand1 = head.operand1;
  assign out_operand2 = head.operand2;
  assign out_rd       = head.rd;
  assign out_illegal  = head.illegal;

endmodule
